// File: rtl/sr_fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// sr_fifo_arb_pkg
//  Shared constants and types for the sr_fifo round-robin arbiter.
//  SR_ARB_NREQ_MAX : upper bound on requester ports
//  SR_ARB_CPU      : requester index wired to sr_cpu
//  SR_ARB_DBG      : requester index wired to the debug/host port
//  SR_ARB_STALL_W  : width of each optional stall counter
//  fifoOp_e        : FIFO operation issued in the current cycle
//  srArbCntW()     : occupancy counter width for a given FIFO depth
// -----------------------------------------------------------------------------
package sr_fifo_arb_pkg;

    localparam int SR_ARB_NREQ_MAX = 8;
    localparam int SR_ARB_CPU      = 0;
    localparam int SR_ARB_DBG      = 1;
    localparam int SR_ARB_STALL_W  = 16;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2
    } fifoOp_e;

    // Occupancy must be able to represent 0..DEPTH inclusive.
    function automatic int srArbCntW(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sr_fifo_arb_if.sv
// -----------------------------------------------------------------------------
// sr_fifo_arb_if
//  Requester-side bundle of the sr_fifo arbiter.
//  req_push  : per-requester push request, held until granted
//  req_pop   : per-requester pop request, held until granted
//  req_wdata : packed push data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  gnt       : one-hot combinational grant
//  rdata     : FIFO head word, valid for the granted popping requester
//  modport master : requesters
//  modport slave  : the arbiter
// -----------------------------------------------------------------------------
interface sr_fifo_arb_if #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32
);

    logic [NREQ-1:0]            req_push;
    logic [NREQ-1:0]            req_pop;
    logic [NREQ*DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]      rdata;

    modport master (
        output req_push,
        output req_pop,
        output req_wdata,
        input  gnt,
        input  rdata
    );

    modport slave (
        input  req_push,
        input  req_pop,
        input  req_wdata,
        output gnt,
        output rdata
    );

endinterface

// File: rtl/sr_fifo_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// sr_rr_pick
//  Combinational round-robin picker. Scans elig starting at ptr, wrapping
//  modulo NREQ, and returns the first eligible requester.
//  elig  : in  NREQ   eligible requesters
//  ptr   : in  IDX_W  highest-priority index this cycle (must be < NREQ)
//  gnt   : out NREQ   one-hot selection (all zero when nothing eligible)
//  idx   : out IDX_W  index of the selected requester (0 when none)
//  valid : out 1      some requester was selected
// -----------------------------------------------------------------------------
module sr_rr_pick
    import sr_fifo_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int cand;
            // ptr < NREQ, so a single subtraction performs the wrap.
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!valid && elig[cand]) begin
                valid     = 1'b1;
                idx       = IDX_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_fifo_arb.sv
// -----------------------------------------------------------------------------
// sr_fifo_arb
//  Round-robin arbiter sharing one sr_fifo between NREQ requesters
//  (port 0 = sr_cpu, port 1 = debug/host). At most one FIFO operation is
//  granted per cycle; occupancy is tracked here so push-when-full and
//  pop-when-empty are never issued.
//
//  clk        : in  clock, all state on posedge
//  rst_n      : in  asynchronous active-low reset
//  req        : sr_fifo_arb_if.slave requester bundle (push/pop/wdata/gnt/rdata)
//  fifo_push  : out sr_fifo writeEnable
//  fifo_pop   : out sr_fifo readEnable
//  fifo_wdata : out granted requester's push word, else 0
//  fifo_rdata : in  sr_fifo head word (combinational)
//  count      : out registered occupancy 0..DEPTH
//  full       : out count == DEPTH
//  empty      : out count == 0
//  proto_err  : out sticky, a requester raised push and pop together
//
//  Optional feature, macro SR_FIFO_ARB_STATS_EN:
//  stall_cnt  : out NREQ x 16-bit saturating counters of held-but-ungranted
//               cycles, requester i at [i*16 +: 16]
// -----------------------------------------------------------------------------
module sr_fifo_arb
    import sr_fifo_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sr_fifo_arb_if.slave                 req,
    output logic                         fifo_push,
    output logic                         fifo_pop,
    output logic [DATA_WIDTH-1:0]        fifo_wdata,
    input  logic [DATA_WIDTH-1:0]        fifo_rdata,
    output logic [srArbCntW(DEPTH)-1:0]  count,
    output logic                         full,
    output logic                         empty,
    output logic                         proto_err
`ifdef SR_FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*SR_ARB_STALL_W-1:0] stall_cnt
`endif
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = srArbCntW(DEPTH);

    logic [NREQ-1:0]       popElig;
    logic [NREQ-1:0]       pushElig;
    logic [NREQ-1:0]       pickGnt;
    logic [IDX_W-1:0]      pickIdx;
    logic                  pickValid;
    logic [IDX_W-1:0]      rrPtr;
    logic [IDX_W-1:0]      nextPtr;
    logic [DATA_WIDTH-1:0] wdataSel;
    fifoOp_e               op;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop always wins over a push from the same requester, so a requester
    // raising both is only push-eligible when it is not also popping.
    always_comb begin
        popElig  = '0;
        pushElig = '0;
        for (int i = 0; i < NREQ; i++) begin
            popElig[i]  = req.req_pop[i] & ~empty;
            pushElig[i] = req.req_push[i] & ~req.req_pop[i] & ~full;
        end
    end

    sr_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) uPick (
        .elig  (popElig | pushElig),
        .ptr   (rrPtr),
        .gnt   (pickGnt),
        .idx   (pickIdx),
        .valid (pickValid)
    );

    // Gating with rst_n keeps grants and FIFO strobes low while in reset even
    // though the picker is purely combinational.
    always_comb begin
        op = OP_NONE;
        if (rst_n && pickValid) begin
            op = (|(pickGnt & popElig)) ? OP_POP : OP_PUSH;
        end
    end

    assign req.gnt   = rst_n ? pickGnt : '0;
    assign req.rdata = fifo_rdata;
    assign fifo_push = (op == OP_PUSH);
    assign fifo_pop  = (op == OP_POP);

    always_comb begin
        wdataSel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pickGnt[i]) begin
                wdataSel = req.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_wdata = fifo_push ? wdataSel : '0;

    assign nextPtr = (pickIdx == IDX_W'(NREQ - 1)) ? '0 : pickIdx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr     <= '0;
            count     <= '0;
            proto_err <= 1'b0;
        end else begin
            if (op != OP_NONE) begin
                rrPtr <= nextPtr;
            end
            case (op)
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
            if (|(req.req_push & req.req_pop)) begin
                proto_err <= 1'b1;
            end
        end
    end

`ifdef SR_FIFO_ARB_STATS_EN
    function automatic logic [SR_ARB_STALL_W-1:0] satInc(input logic [SR_ARB_STALL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [SR_ARB_STALL_W-1:0] stallReg [NREQ];
    logic [NREQ-1:0]           stalled;

    // Any held request that is not granted counts, whether it was blocked by
    // full/empty or simply lost arbitration.
    assign stalled = (req.req_push | req.req_pop) & ~pickGnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                stallReg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stalled[i]) begin
                    stallReg[i] <= satInc(stallReg[i]);
                end
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            stall_cnt[i*SR_ARB_STALL_W +: SR_ARB_STALL_W] = stallReg[i];
        end
    end
`endif

endmodule
